// File: rtl/regfile_pkg.sv
// regfile_pkg: shared defaults and word/index types for the multi-port
// register file and its busy scoreboard.
package regfile_pkg;

  localparam int DATA_W_DEF   = 32;
  localparam int NUM_REGS_DEF = 32;
  localparam int IDX_W_DEF    = $clog2(NUM_REGS_DEF);

  typedef logic [IDX_W_DEF-1:0]  reg_idx_t;
  typedef logic [DATA_W_DEF-1:0] reg_word_t;

  // True when the index addresses the hardwired zero register.
  function automatic logic is_zero_idx(input logic [31:0] idx, input logic zero_en);
    return zero_en && (idx == 32'd0);
  endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: per-register busy bits. Allocation (a new producer
// issuing) sets a bit, a writeback clears it, and allocation wins when both
// hit the same register in one cycle because the new producer supersedes
// the old one.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int NUM_REGS = NUM_REGS_DEF,
  parameter int NUM_WR   = 2,
  parameter int ZERO_REG = 1,
  localparam int IDX_W   = $clog2(NUM_REGS)
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    alloc_en,
  input  logic [IDX_W-1:0]        alloc_idx,
  input  logic [NUM_WR-1:0]       wr_en,
  input  logic [NUM_WR*IDX_W-1:0] wr_idx,
  output logic [NUM_REGS-1:0]     busy_vec
);

  localparam logic ZERO_EN = (ZERO_REG != 0);

  logic [NUM_REGS-1:0] busy_r;
  logic [NUM_REGS-1:0] busy_nxt_s;
  logic [NUM_REGS-1:0] set_s;
  logic [NUM_REGS-1:0] clr_s;

  // Decode set/clear requests per register and apply set-over-clear priority.
  always_comb begin
    set_s      = '0;
    clr_s      = '0;
    busy_nxt_s = busy_r;
    for (int r = 0; r < NUM_REGS; r++) begin
      if (alloc_en && (alloc_idx == IDX_W'(r)) && !is_zero_idx(32'(r), ZERO_EN)) begin
        set_s[r] = 1'b1;
      end else begin
        set_s[r] = 1'b0;
      end
      for (int w = 0; w < NUM_WR; w++) begin
        if (wr_en[w] && (wr_idx[w*IDX_W +: IDX_W] == IDX_W'(r))) begin
          clr_s[r] = 1'b1;
        end else begin
          clr_s[r] = clr_s[r];
        end
      end
      if (set_s[r]) begin
        busy_nxt_s[r] = 1'b1;
      end else if (clr_s[r]) begin
        busy_nxt_s[r] = 1'b0;
      end else begin
        busy_nxt_s[r] = busy_r[r];
      end
    end
  end

  // Busy state register; reset discards any same-edge alloc or writeback.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      busy_r <= '0;
    end else begin
      busy_r <= busy_nxt_s;
    end
  end

  assign busy_vec = busy_r;

endmodule

// File: rtl/regfile_mp.sv
// regfile_mp: parametrised multi-port integer register file with NUM_RD
// combinational read ports, NUM_WR synchronous write ports (highest port
// number wins on a same-index collision) and a busy scoreboard.
// Optional build macro REGFILE_BYPASS_EN adds same-cycle write-to-read
// forwarding; without it reads return stored state only.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int NUM_REGS = NUM_REGS_DEF,
  parameter int NUM_RD   = 2,
  parameter int NUM_WR   = 2,
  parameter int ZERO_REG = 1,
  localparam int IDX_W   = $clog2(NUM_REGS)
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic [NUM_RD*IDX_W-1:0]  rd_idx,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_busy,
  input  logic [NUM_WR-1:0]        wr_en,
  input  logic [NUM_WR*IDX_W-1:0]  wr_idx,
  input  logic [NUM_WR*DATA_W-1:0] wr_data,
  input  logic                     alloc_en,
  input  logic [IDX_W-1:0]         alloc_idx,
  output logic [NUM_REGS-1:0]      busy_vec
);

  localparam logic ZERO_EN = (ZERO_REG != 0);

  logic [DATA_W-1:0]   regs_r     [NUM_REGS];
  logic [DATA_W-1:0]   regs_nxt_s [NUM_REGS];
  logic [IDX_W-1:0]    rd_sel_s   [NUM_RD];
  logic [NUM_RD*DATA_W-1:0] rd_data_s;
  logic [NUM_RD-1:0]   rd_busy_s;
  logic [NUM_REGS-1:0] busy_s;
`ifdef REGFILE_BYPASS_EN
  logic [NUM_RD-1:0]   fwd_s;
`endif

  regfile_scoreboard #(
    .NUM_REGS (NUM_REGS),
    .NUM_WR   (NUM_WR),
    .ZERO_REG (ZERO_REG)
  ) u_scoreboard (
    .CLK       (CLK),
    .RST       (RST),
    .alloc_en  (alloc_en),
    .alloc_idx (alloc_idx),
    .wr_en     (wr_en),
    .wr_idx    (wr_idx),
    .busy_vec  (busy_s)
  );

  assign busy_vec = busy_s;

  // Next register contents: later write ports overwrite earlier ones, and
  // the zero register never changes.
  always_comb begin
    for (int r = 0; r < NUM_REGS; r++) begin
      regs_nxt_s[r] = regs_r[r];
      for (int w = 0; w < NUM_WR; w++) begin
        if (wr_en[w] && (wr_idx[w*IDX_W +: IDX_W] == IDX_W'(r))) begin
          regs_nxt_s[r] = wr_data[w*DATA_W +: DATA_W];
        end else begin
          regs_nxt_s[r] = regs_nxt_s[r];
        end
      end
      if (is_zero_idx(32'(r), ZERO_EN)) begin
        regs_nxt_s[r] = '0;
      end else begin
        regs_nxt_s[r] = regs_nxt_s[r];
      end
    end
  end

  // Data array; reset clears every register and drops same-edge writes.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int r = 0; r < NUM_REGS; r++) begin
        regs_r[r] <= '0;
      end
    end else begin
      for (int r = 0; r < NUM_REGS; r++) begin
        regs_r[r] <= regs_nxt_s[r];
      end
    end
  end

  // Unpack the per-port read indices.
  always_comb begin
    for (int p = 0; p < NUM_RD; p++) begin
      rd_sel_s[p] = rd_idx[p*IDX_W +: IDX_W];
    end
  end

  // Read muxes from stored state, with optional same-cycle forwarding.
  always_comb begin
    rd_data_s = '0;
    rd_busy_s = '0;
`ifdef REGFILE_BYPASS_EN
    fwd_s     = '0;
`endif
    for (int p = 0; p < NUM_RD; p++) begin
      rd_data_s[p*DATA_W +: DATA_W] = regs_r[rd_sel_s[p]];
      rd_busy_s[p]                  = busy_s[rd_sel_s[p]];
`ifdef REGFILE_BYPASS_EN
      for (int w = 0; w < NUM_WR; w++) begin
        if (wr_en[w] && (wr_idx[w*IDX_W +: IDX_W] == rd_sel_s[p])) begin
          rd_data_s[p*DATA_W +: DATA_W] = wr_data[w*DATA_W +: DATA_W];
          fwd_s[p]                      = 1'b1;
        end else begin
          fwd_s[p] = fwd_s[p];
        end
      end
      // A forwarded writeback retires the producer unless a new one
      // allocates the same register this cycle.
      if (fwd_s[p] && !(alloc_en && (alloc_idx == rd_sel_s[p]))) begin
        rd_busy_s[p] = 1'b0;
      end else begin
        rd_busy_s[p] = rd_busy_s[p];
      end
`endif
      if (is_zero_idx(32'(rd_sel_s[p]), ZERO_EN)) begin
        rd_data_s[p*DATA_W +: DATA_W] = '0;
        rd_busy_s[p]                  = 1'b0;
      end else begin
        rd_busy_s[p] = rd_busy_s[p];
      end
    end
  end

  assign rd_data = rd_data_s;
  assign rd_busy = rd_busy_s;

endmodule
